load_store_unit: RTL and testbench

//  Core-side initiator for the synchronous data memory (1-cycle registered read, per-byte write strobes).

---
 rtl/load_store_unit.sv | 193 +++++++++++++++++++
 tb/tb_load_store_unit.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// RV32 load/store unit driving a synchronous data memory (registered read, byte strobes).
// Optional MISALIGN_SPLIT_EN: misaligned legal accesses become two word accesses instead of errors.
`timescale 1ns/1ps
module load_store_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_din,
  output logic [3:0]  mem_we,
  input  logic [31:0] mem_dout
);

  localparam int unsigned DW = 32;
  localparam int unsigned SW = DW / 8;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    RDATA = 3'd2,
    RESP  = 3'd3
`ifdef MISALIGN_SPLIT_EN
    , ISSUE2 = 3'd4
`endif
  } state_t;

  state_t          state, state_d;
  logic            op_we, op_we_d;
  logic [2:0]      op_f3, op_f3_d;
  logic [1:0]      op_off, op_off_d;
  logic [DW-1:0]   mem_addr_d, mem_din_d, rsp_rdata_d;
  logic [SW-1:0]   mem_we_d;
  logic            rsp_err_d;

  logic            illegal_c, misaligned_c, bad_c;
  logic [SW-1:0]   mask_c, strobe_lo_c;
  logic [DW-1:0]   wdata_rot_c, raw_c, ext_c;
  logic [4:0]      req_sh_c, op_sh_c;

`ifdef MISALIGN_SPLIT_EN
  logic            split, split_d;
  logic [SW-1:0]   hi_we, hi_we_d;
  logic [DW-1:0]   lo_word, lo_word_d;
`endif

  // Request decode: legality, alignment, byte lanes
  always_comb begin
    illegal_c = (req_funct3 == 3'b011) || (req_funct3 == 3'b110) || (req_funct3 == 3'b111) ||
                (req_we && req_funct3[2]);
    case (req_funct3[1:0])
      2'b00:   mask_c = 4'b0001;
      2'b01:   mask_c = 4'b0011;
      default: mask_c = 4'b1111;
    endcase
    misaligned_c = ((req_funct3[1:0] == 2'b01) && (req_addr[1:0] == 2'b11)) ||
                   ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
`ifdef MISALIGN_SPLIT_EN
    bad_c = illegal_c;
`else
    bad_c = illegal_c || misaligned_c;
`endif
    req_sh_c    = {req_addr[1:0], 3'b000};
    strobe_lo_c = 4'(mask_c << req_addr[1:0]);
    wdata_rot_c = 32'(({req_wdata, req_wdata} << req_sh_c) >> DW);
  end

  // Load data alignment and extension
  always_comb begin
    op_sh_c = {op_off, 3'b000};
`ifdef MISALIGN_SPLIT_EN
    raw_c = split ? 32'({mem_dout, lo_word} >> op_sh_c) : (mem_dout >> op_sh_c);
`else
    raw_c = mem_dout >> op_sh_c;
`endif
    case (op_f3)
      3'b000:  ext_c = {{24{raw_c[7]}}, raw_c[7:0]};
      3'b001:  ext_c = {{16{raw_c[15]}}, raw_c[15:0]};
      3'b100:  ext_c = {24'd0, raw_c[7:0]};
      3'b101:  ext_c = {16'd0, raw_c[15:0]};
      default: ext_c = raw_c;
    endcase
  end

  // Next-state and next-output logic
  always_comb begin
    state_d     = state;
    op_we_d     = op_we;
    op_f3_d     = op_f3;
    op_off_d    = op_off;
    mem_addr_d  = mem_addr;
    mem_din_d   = mem_din;
    mem_we_d    = '0;
    rsp_err_d   = rsp_err;
    rsp_rdata_d = rsp_rdata;
`ifdef MISALIGN_SPLIT_EN
    split_d     = split;
    hi_we_d     = hi_we;
    lo_word_d   = lo_word;
`endif
    case (state)
      IDLE: begin
        if (req_valid) begin
          op_we_d     = req_we;
          op_f3_d     = req_funct3;
          op_off_d    = req_addr[1:0];
          rsp_rdata_d = '0;
          rsp_err_d   = bad_c;
          if (bad_c) begin
            state_d = RESP;
          end else begin
            mem_addr_d = {req_addr[31:2], 2'b00};
            mem_din_d  = wdata_rot_c;
            mem_we_d   = req_we ? strobe_lo_c : 4'b0000;
`ifdef MISALIGN_SPLIT_EN
            split_d    = misaligned_c;
            hi_we_d    = req_we ? 4'((8'(mask_c) << req_addr[1:0]) >> 4) : 4'b0000;
`endif
            state_d    = ISSUE;
          end
        end
      end
      ISSUE: begin
`ifdef MISALIGN_SPLIT_EN
        if (split) begin
          mem_addr_d = mem_addr + 32'd4;
          mem_we_d   = hi_we;
          state_d    = ISSUE2;
        end else
`endif
        state_d = op_we ? RESP : RDATA;
      end
`ifdef MISALIGN_SPLIT_EN
      ISSUE2: begin
        lo_word_d = mem_dout;
        state_d   = op_we ? RESP : RDATA;
      end
`endif
      RDATA: begin
        rsp_rdata_d = ext_c;
        state_d     = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      op_we     <= 1'b0;
      op_f3     <= 3'b000;
      op_off    <= 2'b00;
      mem_addr  <= '0;
      mem_din   <= '0;
      mem_we    <= '0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
      req_ready <= 1'b1;
`ifdef MISALIGN_SPLIT_EN
      split     <= 1'b0;
      hi_we     <= '0;
      lo_word   <= '0;
`endif
    end else begin
      state     <= state_d;
      op_we     <= op_we_d;
      op_f3     <= op_f3_d;
      op_off    <= op_off_d;
      mem_addr  <= mem_addr_d;
      mem_din   <= mem_din_d;
      mem_we    <= mem_we_d;
      rsp_valid <= (state == RESP);
      rsp_err   <= rsp_err_d;
      rsp_rdata <= rsp_rdata_d;
      req_ready <= (state_d == IDLE);
`ifdef MISALIGN_SPLIT_EN
      split     <= split_d;
      hi_we     <= hi_we_d;
      lo_word   <= lo_word_d;
`endif
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a byte-strobed synchronous memory model.
`timescale 1ns/1ps
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata, mem_addr, mem_din, mem_dout;
  logic [3:0]  mem_we;
  logic        mem_clr;

  int total = 0;
  int bad   = 0;

  logic [31:0] mem_arr [0:63];

  load_store_unit dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_addr(mem_addr), .mem_din(mem_din), .mem_we(mem_we), .mem_dout(mem_dout)
  );

  always #5 clk = ~clk;

  // Synchronous memory: registered read, per-byte write
  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 64; i++) mem_arr[i] <= 32'd0;
      mem_dout <= 32'd0;
    end else begin
      mem_dout <= mem_arr[mem_addr[7:2]];
      for (int b = 0; b < 4; b++)
        if (mem_we[b]) mem_arr[mem_addr[7:2]][8*b +: 8] <= mem_din[8*b +: 8];
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  // One transaction; reports first/second-cycle memory activity and response timing
  task automatic xact(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                      input logic [31:0] wd,
                      output logic [31:0] a0, output logic [31:0] a1, output logic [31:0] d0,
                      output logic [3:0] w0, output logic [3:0] w1, output int wcnt,
                      output int lat, output logic [31:0] rd, output logic er);
    int n;
    n = 0;
    @(negedge clk);
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
    @(posedge clk); #1;
    req_valid = 1'b0;
    a0 = mem_addr; d0 = mem_din; w0 = mem_we; a1 = 32'd0; w1 = 4'd0;
    wcnt = (mem_we != 4'd0) ? 1 : 0;
    lat = 99; rd = 32'hX; er = 1'bX;
    for (int i = 1; i <= 12; i++) begin
      @(posedge clk); #1;
      if (i == 1) begin
        a1 = mem_addr;
        w1 = mem_we;
      end
      if (mem_we != 4'd0) wcnt++;
      if (rsp_valid) begin
        lat = i; rd = rsp_rdata; er = rsp_err;
        break;
      end
    end
  endtask

  logic [31:0] a0, a1, d0, rd;
  logic [3:0]  w0, w1;
  logic        er;
  int          wcnt, lat;
  int          rsp_edges [2];
  logic [31:0] rsp_data2;
  int          nrsp;

  initial begin
    rst = 1'b1; mem_clr = 1'b1; req_valid = 1'b0; req_we = 1'b0;
    req_funct3 = 3'b000; req_addr = 32'd0; req_wdata = 32'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ready", 32'(req_ready), 32'd1);
    check("rst_rspv", 32'(rsp_valid), 32'd0);
    check("rst_we", 32'(mem_we), 32'd0);
    check("rst_addr", mem_addr, 32'd0);
    check("rst_rdata", rsp_rdata, 32'd0);
    rst = 1'b0; mem_clr = 1'b0;

    xact(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, a0, a1, d0, w0, w1, wcnt, lat, rd, er);
    check("sw_addr", a0, 32'h10);
    check("sw_din", d0, 32'hDEADBEEF);
    check("sw_we", 32'(w0), 32'hF);
    check("sw_wcnt", 32'(wcnt), 32'd1);
    check("sw_lat", 32'(lat), 32'd2);
    check("sw_err", 32'(er), 32'd0);
    check("sw_rdata", rd, 32'd0);

    xact(1'b0, 3'b010, 32'h10, 32'd0, a0, a1, d0, w0, w1, wcnt, lat, rd, er);
    check("lw_rdata", rd, 32'hDEADBEEF);
    check("lw_lat", 32'(lat), 32'd3);
    check("lw_wcnt", 32'(wcnt), 32'd0);

    xact(1'b1, 3'b000, 32'h13, 32'h000000A5, a0, a1, d0, w0, w1, wcnt, lat, rd, er);
    check("sb_we", 32'(w0), 32'h8);
    check("sb_din", d0, 32'hA5000000);
    xact(1'b0, 3'b000, 32'h13, 32'd0, a0, a1, d0, w0, w1, wcnt, lat, rd, er);
    check("lb_rdata", rd, 32'hFFFFFFA5);
    xact(1'b0, 3'b100, 32'h13, 32'd0, a0, a1, d0, w0, w1, wcnt, lat, rd, er);
    check("lbu_rdata", rd, 32'h000000A5);

    xact(1'b1, 3'b001, 32'h12, 32'h00008001, a0, a1, d0, w0, w1, wcnt, lat, rd, er);
    check("sh_we", 32'(w0), 32'hC);
    xact(1'b0, 3'b001, 32'h12, 32'd0, a0, a1, d0, w0, w1, wcnt, lat, rd, er);
    check("lh_rdata", rd, 32'hFFFF8001);
    xact(1'b0, 3'b101, 32'h12, 32'd0, a0, a1, d0, w0, w1, wcnt, lat, rd, er);
    check("lhu_rdata", rd, 32'h00008001);
    xact(1'b0, 3'b010, 32'h10, 32'd0, a0, a1, d0, w0, w1, wcnt, lat, rd, er);
    check("merge_word", rd, 32'h8001BEEF);

    xact(1'b1, 3'b010, 32'h10, 32'h44332211, a0, a1, d0, w0, w1, wcnt, lat, rd, er);
    xact(1'b1, 3'b010, 32'h14, 32'h88776655, a0, a1, d0, w0, w1, wcnt, lat, rd, er);
    xact(1'b0, 3'b010, 32'h11, 32'd0, a0, a1, d0, w0, w1, wcnt, lat, rd, er);
`ifdef MISALIGN_SPLIT_EN
    check("mlw_a0", a0, 32'h10);
    check("mlw_a1", a1, 32'h14);
    check("mlw_rdata", rd, 32'h55443322);
    check("mlw_lat", 32'(lat), 32'd4);
    check("mlw_err", 32'(er), 32'd0);
    xact(1'b1, 3'b010, 32'h13, 32'hCAFEF00D, a0, a1, d0, w0, w1, wcnt, lat, rd, er);
    check("msw_we0", 32'(w0), 32'h8);
    check("msw_we1", 32'(w1), 32'h7);
    check("msw_lat", 32'(lat), 32'd3);
    xact(1'b0, 3'b010, 32'h10, 32'd0, a0, a1, d0, w0, w1, wcnt, lat, rd, er);
    check("msw_lo", rd, 32'h0D332211);
    xact(1'b0, 3'b010, 32'h14, 32'd0, a0, a1, d0, w0, w1, wcnt, lat, rd, er);
    check("msw_hi", rd, 32'h88CAFEF0);
`else
    check("mlw_err", 32'(er), 32'd1);
    check("mlw_rdata", rd, 32'd0);
    check("mlw_lat", 32'(lat), 32'd1);
    check("mlw_wcnt", 32'(wcnt), 32'd0);
    xact(1'b1, 3'b010, 32'h13, 32'hCAFEF00D, a0, a1, d0, w0, w1, wcnt, lat, rd, er);
    check("msw_err", 32'(er), 32'd1);
    check("msw_wcnt", 32'(wcnt), 32'd0);
    xact(1'b0, 3'b010, 32'h14, 32'd0, a0, a1, d0, w0, w1, wcnt, lat, rd, er);
    check("msw_untouched", rd, 32'h88776655);
`endif

    xact(1'b0, 3'b011, 32'h10, 32'd0, a0, a1, d0, w0, w1, wcnt, lat, rd, er);
    check("ill_ld_err", 32'(er), 32'd1);
    check("ill_ld_lat", 32'(lat), 32'd1);
    check("ill_ld_rdata", rd, 32'd0);
    xact(1'b1, 3'b100, 32'h10, 32'h11111111, a0, a1, d0, w0, w1, wcnt, lat, rd, er);
    check("ill_st_err", 32'(er), 32'd1);
    check("ill_st_lat", 32'(lat), 32'd1);
    check("ill_st_wcnt", 32'(wcnt), 32'd0);

    // Reset while the store sits in ISSUE
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'h20; req_wdata = 32'h12345678;
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("abort_we_before", 32'(mem_we), 32'hF);
    #1 rst = 1'b1;
    #1 check("abort_we_cleared", 32'(mem_we), 32'd0);
    nrsp = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (rsp_valid) nrsp++;
    end
    @(negedge clk) rst = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      if (rsp_valid) nrsp++;
    end
    check("abort_no_rsp", 32'(nrsp), 32'd0);
    check("abort_ready", 32'(req_ready), 32'd1);
    xact(1'b0, 3'b010, 32'h20, 32'd0, a0, a1, d0, w0, w1, wcnt, lat, rd, er);
    check("abort_no_write", rd, 32'd0);
    check("abort_next_lat", 32'(lat), 32'd3);

    // Back-to-back with req_valid held high
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'h18; req_wdata = 32'h11112222;
    @(posedge clk); #1;
    req_we = 1'b0; req_wdata = 32'd0;
    nrsp = 0; rsp_edges[0] = 0; rsp_edges[1] = 0; rsp_data2 = 32'd0;
    for (int i = 1; i <= 10; i++) begin
      @(posedge clk); #1;
      if (i == 1) check("b2b_busy", 32'(req_ready), 32'd0);
      if (rsp_valid && nrsp < 2) begin
        rsp_edges[nrsp] = i;
        if (nrsp == 1) rsp_data2 = rsp_rdata;
        nrsp++;
        if (nrsp == 2) req_valid = 1'b0;
      end
    end
    req_valid = 1'b0;
    check("b2b_nrsp", 32'(nrsp), 32'd2);
    check("b2b_first", 32'(rsp_edges[0]), 32'd2);
    check("b2b_second", 32'(rsp_edges[1]), 32'd6);
    check("b2b_rdata", rsp_data2, 32'h11112222);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
